// File: rtl/btn_debounce.sv
// btn_debounce
// Multi-channel push-button conditioner. Each raw pin is polarity-corrected,
// synchronized into clk_i and debounced by a per-channel four-state FSM that
// produces a clean level plus single-cycle press/release strobes and an
// optional long-press strobe.
//
// Optional feature macro: BTN_DEBOUNCE_LONG_EN
//   defined   -> per-channel long-press counters drive long_o
//   undefined -> no long counters, long_o tied to 0
//
// Ports:
//   clk_i      in   1      clock
//   rst_i      in   1      asynchronous, active-high reset
//   btn_i      in   N_BTN  raw asynchronous button pins
//   level_o    out  N_BTN  debounced level, 1 = pressed
//   press_o    out  N_BTN  1-cycle strobe on accepted press
//   release_o  out  N_BTN  1-cycle strobe on accepted release
//   long_o     out  N_BTN  1-cycle strobe when a hold reaches LONG_CYCLES
module btn_debounce #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int LONG_CYCLES     = 62500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_PEND   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_PEND = 2'd3;

  // Reject illegal parameterisations at elaboration time.
  if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : gBadLong
    $error("btn_debounce: LONG_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : gBadSync
    $error("btn_debounce: SYNC_STAGES must be >= 2");
  end

  // After this inversion 1 always means "pressed", whatever the pin polarity.
  logic [N_BTN-1:0] btnPol;
  assign btnPol = ACTIVE_LOW ? ~btn_i : btn_i;

  // Synchronizer chain. Flops reset to the released level so that a button
  // already held through reset cannot produce a press during reset.
  logic [N_BTN-1:0] syncPipe_q [SYNC_STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        syncPipe_q[k] <= '0;
      end
    end else begin
      syncPipe_q[0] <= btnPol;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        syncPipe_q[k] <= syncPipe_q[k-1];
      end
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : gChan
    logic             syncIn;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] debCnt_q, debCnt_d;
    logic             pressEv, releaseEv, levelNext;
    logic             level_q, press_q, release_q;

    assign syncIn = syncPipe_q[SYNC_STAGES-1][g];

    // Debounce FSM next-state logic. A pending state counts consecutive
    // cycles of the new level; any return to the old level drops back
    // without emitting anything. With DEBOUNCE_CYCLES == 1 the pending
    // state would accept on its first cycle, so the transition goes
    // straight to the settled state to keep the latency at SYNC_STAGES+1.
    always_comb begin
      state_d   = state_q;
      debCnt_d  = debCnt_q;
      pressEv   = 1'b0;
      releaseEv = 1'b0;
      case (state_q)
        S_RELEASED: begin
          if (syncIn) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = S_PRESSED;
              pressEv = 1'b1;
            end else begin
              state_d  = S_PRESS_PEND;
              debCnt_d = CNT_ONE;
            end
          end
        end
        S_PRESS_PEND: begin
          if (!syncIn) begin
            state_d  = S_RELEASED;
            debCnt_d = '0;
          end else if (debCnt_q == CNT_LAST) begin
            state_d  = S_PRESSED;
            debCnt_d = '0;
            pressEv  = 1'b1;
          end else begin
            debCnt_d = debCnt_q + CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (!syncIn) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d   = S_RELEASED;
              releaseEv = 1'b1;
            end else begin
              state_d  = S_RELEASE_PEND;
              debCnt_d = CNT_ONE;
            end
          end
        end
        S_RELEASE_PEND: begin
          // Bounce back to pressed is a continuation of the same press.
          if (syncIn) begin
            state_d  = S_PRESSED;
            debCnt_d = '0;
          end else if (debCnt_q == CNT_LAST) begin
            state_d   = S_RELEASED;
            debCnt_d  = '0;
            releaseEv = 1'b1;
          end else begin
            debCnt_d = debCnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d  = S_RELEASED;
          debCnt_d = '0;
        end
      endcase
    end

    assign levelNext = (state_d == S_PRESSED) || (state_d == S_RELEASE_PEND);

    // State, counter and registered outputs for this channel.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q   <= S_RELEASED;
        debCnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        debCnt_q  <= debCnt_d;
        level_q   <= levelNext;
        press_q   <= pressEv;
        release_q <= releaseEv;
      end
    end

    assign level_o[g]   = level_q;
    assign press_o[g]   = press_q;
    assign release_o[g] = release_q;

`ifdef BTN_DEBOUNCE_LONG_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_ONE = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] longCnt_q, longCnt_d;
    logic              longEv, long_q;

    // Hold-time counter. It advances on every cycle the channel stays in a
    // pressed state (bounces included), fires once on reaching LONG_CYCLES
    // and then saturates. Leaving for RELEASED clears it and takes priority,
    // so a release on the same cycle suppresses the strobe.
    always_comb begin
      longCnt_d = longCnt_q;
      longEv    = 1'b0;
      if (state_d == S_RELEASED) begin
        longCnt_d = '0;
      end else if (((state_q == S_PRESSED) || (state_q == S_RELEASE_PEND)) &&
                   (longCnt_q != LONG_MAX)) begin
        longCnt_d = longCnt_q + LONG_ONE;
        longEv    = (longCnt_q == LONG_PRE);
      end
    end

    // Long-press counter and strobe register.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        longCnt_q <= '0;
        long_q    <= 1'b0;
      end else begin
        longCnt_q <= longCnt_d;
        long_q    <= longEv;
      end
    end

    assign long_o[g] = long_q;
`else
    assign long_o[g] = 1'b0;
`endif
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button conditioner for the board's mechanical buttons. Each raw asynchronous button input is synchronized into `clk_i`, then debounced by a per-channel four-state FSM. The block produces a clean level, single-cycle press/release strobes and an optional long-press strobe. It is the input-side counterpart to the LED drivers: raw pin in, clean events out to user logic.

## Interface
- `N_BTN`, default 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 1250000: consecutive stable cycles required to accept a change (10 ms at 125 MHz). Must be ≥1.
- `LONG_CYCLES`, default 62500000: cycles held in PRESSED before `long_o` fires (0.5 s). Must be ≥1.
- `SYNC_STAGES`, default 2: synchronizer flop depth. Must be ≥2.
- `ACTIVE_LOW`, default 0: 1 = button pin reads 0 when pressed.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high; clock `clk_i`.
- `btn_i` in N_BTN: raw, asynchronous button pins.
- `level_o` out N_BTN: debounced pressed level, 1 = pressed.
- `press_o` out N_BTN: 1-cycle strobe on accepted press.
- `release_o` out N_BTN: 1-cycle strobe on accepted release.
- `long_o` out N_BTN: 1-cycle strobe when the hold reaches `LONG_CYCLES`.

## Operation
- Polarity: `btn_i` is inverted when `ACTIVE_LOW`=1, then fed to a `SYNC_STAGES`-deep synchronizer. Synchronizer flops reset to the released level (0 after inversion), so reset never creates a false press.
- Per-channel FSM states, with `s` = synchronized input and `cnt` = debounce counter of width $clog2(DEBOUNCE_CYCLES+1):
  - RELEASED: if `s`=1, go to PRESS_PEND with `cnt`=1.
  - PRESS_PEND:
    - if `s`=0, go to RELEASED, glitch discarded, no outputs.
    - else if `cnt`==DEBOUNCE_CYCLES-1, go to PRESSED: `level_o`=1, `press_o` pulses.
    - else `cnt`++.
  - PRESSED: if `s`=0, go to RELEASE_PEND with `cnt`=1.
  - RELEASE_PEND:
    - if `s`=1, go back to PRESSED; this is not a new press, and the long counter is not reset.
    - else if `cnt`==DEBOUNCE_CYCLES-1, go to RELEASED: `level_o`=0, `release_o` pulses.
    - else `cnt`++.
- Special case `DEBOUNCE_CYCLES`=1: the PEND state is accepted on its first cycle.
- Long press (macro enabled):
  - A per-channel counter runs while in PRESSED or RELEASE_PEND.
  - `long_o` pulses once when it reaches `LONG_CYCLES`, then the counter saturates, so there is at most one pulse per press.
  - The counter clears on entry to RELEASED.
- Channels are fully independent. Simultaneous events on several channels assert several bits in the same cycle.
- `press_o` and `release_o` never assert on the same channel in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0. All FSMs reset to RELEASED and all counters to 0.
- Press latency: call the first `clk_i` edge that samples `btn_i` in its pressed state edge 1. `level_o` and `press_o` rise at edge `SYNC_STAGES+DEBOUNCE_CYCLES`. Release latency is identical.
- `press_o`, `release_o` and `long_o` are high for exactly one cycle.
- `long_o` asserts `LONG_CYCLES` edges after the edge on which `press_o` asserted.
- A pressed level lasting `DEBOUNCE_CYCLES-1` synchronized cycles is rejected. A level lasting exactly `DEBOUNCE_CYCLES` cycles is accepted.
- Reset mid-operation: outputs drop to 0 asynchronously and no `release_o` is emitted. A button still held after reset deassertion is reported as a fresh press after the full latency.

## Configuration
- `BTN_DEBOUNCE_LONG_EN` defined: long-press counters and `long_o` are implemented as described.
- `BTN_DEBOUNCE_LONG_EN` undefined: no long counters are instantiated and `long_o` is tied to 0. All other behaviour is unchanged.

## Test plan
All scenarios use `N_BTN`=2, `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2, `LONG_CYCLES`=10, with the macro defined unless noted.

- Clean press: `btn_i[0]` goes 0→1 and is held → `level_o[0]`=1 and `press_o[0]`=1 for one cycle at edge 6; `long_o[0]` pulses at edge 16; no further `long_o`.
- Glitch reject: a 3-cycle high pulse on `btn_i[0]` → all outputs stay 0. A 4-cycle pulse → press accepted, followed by release 6 edges after the falling sample.
- Bounce during release: held button drops for 2 cycles then returns high → no `release_o`; `level_o` stays 1; `long_o` is not re-armed.
- Simultaneous channels with `ACTIVE_LOW`=1: both pins 1 through reset, then both driven to 0 → `press_o`=2'b11 in the same cycle at edge 6; no event during or after reset while the pins are 1.
- Reset mid-press: assert `rst_i` while `level_o[1]`=1 with the button held → outputs 0 immediately with no `release_o`; after deassertion a fresh `press_o[1]` follows 6 edges later.
- Macro undefined: repeat the clean-press scenario → identical press/release timing, `long_o` constantly 0.
